button_event_decoder: RTL and testbench
=======================================

Name: button_event_decoder

Overview:
- Sits directly downstream of the debouncer; consumes its clean level output `debouncer_out`, connected here as `db_in`.
- Classifies button activity into single-cycle event pulses: press, release, single click, double click, long press and auto-repeat.
- Feeds the user-interface control logic, which acts only on these pulses and never on raw levels.

Parameters:
- LONG_CYCLES, 1000: consecutive high samples needed to qualify a long press; must be ≥ 2.
- DCLICK_GAP, 250: consecutive low samples after the first release that end the double-click window; must be ≥ 1.
- REPEAT_CYCLES, 200: high samples between repeat pulses while in long hold; 0 disables repeat.
- CNT_W, 16: counter width; must hold max(LONG_CYCLES, DCLICK_GAP, REPEAT_CYCLES).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- en  input  1  decoder enable; low forces IDLE and suppresses all pulses
- db_in  input  1  debounced button level from the debouncer
- press_pulse  output  1  rising edge of db_in accepted
- release_pulse  output  1  falling edge of db_in accepted
- single_click  output  1  short press with no second press inside the gap window
- double_click  output  1  second short press completed inside the gap window
- long_press  output  1  db_in held for LONG_CYCLES samples
- repeat_pulse  output  1  periodic pulse while long hold continues
- state_o  output  3  current state, for debug

Behaviour:
- Clock and reset: clock clk; reset rst_n, asynchronous, active-low.
- Reset values:
  - State is IDLE, counter is 0, prev (registered db_in) is 0.
  - All outputs are 0; state_o = 0.
- Edge detection: rise = db_in & ~prev; fall = ~db_in & prev. prev updates every cycle, including when en = 0.
- Output timing: all outputs are registered. A pulse is high for exactly one cycle, in the cycle after the sampling edge where its condition holds.
- Sample counting: "sample N" means the Nth consecutive sample of the same level, where the edge sample is #1. The counter loads 1 on entering a counting state.
- State encodings, in a shared package: IDLE=0, PRESSED=1, WAIT_GAP=2, SECOND=3, LONG_HELD=4.
- IDLE:
  - On rise → PRESSED, with press_pulse.
- PRESSED:
  - On fall → WAIT_GAP, with release_pulse.
  - At high sample #LONG_CYCLES → LONG_HELD, with long_press.
- WAIT_GAP:
  - On rise → SECOND, with press_pulse.
  - At low sample #DCLICK_GAP → IDLE, with single_click.
- SECOND:
  - On fall → IDLE, with release_pulse and double_click asserted in the same cycle.
  - At high sample #LONG_CYCLES → LONG_HELD, with long_press; the double click is cancelled.
- LONG_HELD:
  - If REPEAT_CYCLES > 0, repeat_pulse fires on every REPEAT_CYCLES-th high sample after the long_press sample; the counter then reloads.
  - On fall → IDLE, with release_pulse. No click event is issued.
- Each sample is either high or low, so rise and a timeout can never coincide. A timeout check uses the same sample as the edge check, and the edge takes priority.
- Counter: saturates at its maximum value and never wraps.
- en = 0:
  - State is forced to IDLE and the counter cleared; all pulses are 0 from the next cycle.
  - On re-enable while db_in is already high, no press is seen because prev is already 1. A new press is only seen after a release.
- Reset mid-operation: everything returns to reset values immediately and asynchronously. No pulse is emitted on reset exit, even if db_in is high.
- Unused encodings 5–7 → IDLE on the next edge, with no pulses.

Decomposition:
- Package btn_evt_pkg holds the state encodings (3-bit localparams) and the state width constant.
- One sub-module, edge_detect: holds prev and outputs rise/fall. It is reusable by other debounced inputs.
- Counter and FSM stay in the top module.

Test Plan (LONG_CYCLES=8, DCLICK_GAP=5, REPEAT_CYCLES=3, en=1 unless stated):
- Reset check: assert rst_n=0 with db_in=1, release it → all outputs 0 during reset; no press_pulse after release until db_in goes 0 then 1.
- Single click: db_in high 3 cycles, then low 6 cycles →
  - press_pulse one cycle after the rising sample;
  - release_pulse one cycle after the falling sample;
  - single_click one cycle after the 5th low sample;
  - no other pulses.
- Double click: high 3, low 4, high 2, low →
  - two press_pulse and two release_pulse;
  - double_click coincident with the second release_pulse;
  - no single_click.
- Gap boundary: high 3, low exactly 5, then high → single_click at low sample 5, then a fresh press_pulse starting a new PRESSED sequence.
- Long press with repeat: high 15 cycles, then low →
  - long_press at high sample 8;
  - repeat_pulse at samples 11 and 14;
  - release_pulse on the fall;
  - no click pulses.
- Enable gating: hold high 4 cycles, drop en for 3 cycles, restore en while still high, then release →
  - no pulses while en=0;
  - no press_pulse at re-enable;
  - release_pulse only if state ≠ IDLE (expected: none, since state is IDLE).

Source files
------------

// File: rtl/btn_evt_pkg.sv
// Shared definitions for the button event decoder: state width and state encodings.
package btn_evt_pkg;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_PRESSED   = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_GAP  = 3'd2;
  localparam logic [STATE_W-1:0] ST_SECOND    = 3'd3;
  localparam logic [STATE_W-1:0] ST_LONG_HELD = 3'd4;
endpackage

// File: rtl/button_event_decoder_edge_detect.sv
// Rise/fall detector for a debounced level; reusable for any clean input.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);
  logic r_prev;
  logic r_armed;

  // A rise only counts once a low has been sampled since reset, so a level
  // already high when reset lifts never looks like a fresh press.
  assign o_rise = i_d & ~r_prev & r_armed;
  assign o_fall = ~i_d & r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= i_d;
      r_armed <= r_armed | ~i_d;
    end
  end
endmodule

// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into single-cycle press/release/click/long/repeat pulses.
module button_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int LONG_CYCLES   = 1000,
  parameter int DCLICK_GAP    = 250,
  parameter int REPEAT_CYCLES = 200,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       db_in,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       single_click,
  output logic       double_click,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic [2:0] state_o
);
  localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(DCLICK_GAP);
  localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_CYCLES);

  logic               w_rise;
  logic               w_fall;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [STATE_W-1:0] r_state;
  logic [CNT_W-1:0]   r_cnt;

  edge_detect u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (db_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // r_cnt holds the index of the previous sample of the current level, so
  // w_cnt_inc is the index of the sample being taken now.
  always_comb begin
    w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  end

  assign state_o = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      single_click  <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      single_click  <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      if (!en) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cnt <= '0;
            if (w_rise) begin
              r_state     <= ST_PRESSED;
              r_cnt       <= CNT_W'(1);
              press_pulse <= 1'b1;
            end
          end
          ST_PRESSED: begin
            if (w_fall) begin
              release_pulse <= 1'b1;
              // A one-sample gap window already expires on the falling sample.
              if (DCLICK_GAP == 1) begin
                single_click <= 1'b1;
                r_state      <= ST_IDLE;
                r_cnt        <= '0;
              end else begin
                r_state <= ST_WAIT_GAP;
                r_cnt   <= CNT_W'(1);
              end
            end else if (w_cnt_inc == LONG_C) begin
              r_state    <= ST_LONG_HELD;
              r_cnt      <= CNT_W'(1);
              long_press <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          ST_WAIT_GAP: begin
            if (w_rise) begin
              r_state     <= ST_SECOND;
              r_cnt       <= CNT_W'(1);
              press_pulse <= 1'b1;
            end else if (w_cnt_inc == GAP_C) begin
              r_state      <= ST_IDLE;
              r_cnt        <= '0;
              single_click <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          ST_SECOND: begin
            if (w_fall) begin
              r_state       <= ST_IDLE;
              r_cnt         <= '0;
              release_pulse <= 1'b1;
              double_click  <= 1'b1;
            end else if (w_cnt_inc == LONG_C) begin
              r_state    <= ST_LONG_HELD;
              r_cnt      <= CNT_W'(1);
              long_press <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          ST_LONG_HELD: begin
            // The long_press sample is period slot 1; slot REPEAT_CYCLES+1 fires.
            if (w_fall) begin
              r_state       <= ST_IDLE;
              r_cnt         <= '0;
              release_pulse <= 1'b1;
            end else if ((REPEAT_CYCLES > 0) && (r_cnt == REPEAT_C)) begin
              r_cnt        <= CNT_W'(1);
              repeat_pulse <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: run-length reference model, per-cycle compare, directed pulse counts.
module tb_button_event_decoder;
  localparam int LONG   = 8;
  localparam int GAP    = 5;
  localparam int REP    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       db_in = 1'b0;
  logic       press_pulse, release_pulse, single_click, double_click;
  logic       long_press, repeat_pulse;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  int cnt_press, cnt_rel, cnt_single, cnt_double, cnt_long, cnt_rep;

  // model state
  int   m_mode = 0;
  int   m_run = 0;
  logic m_last = 1'b0;
  logic m_prev = 1'b0;
  logic m_armed = 1'b0;

  button_event_decoder #(
    .LONG_CYCLES   (LONG),
    .DCLICK_GAP    (GAP),
    .REPEAT_CYCLES (REP),
    .CNT_W         (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .db_in         (db_in),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .single_click  (single_click),
    .double_click  (double_click),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .state_o       (state_o)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // Reference model: classification from run lengths of consecutive samples.
  always @(posedge clk) begin
    logic rise, fall;
    logic p, r, s, d, l, rp;
    p = 0; r = 0; s = 0; d = 0; l = 0; rp = 0;
    if (!rst_n) begin
      m_mode = 0; m_run = 0; m_last = 0; m_prev = 0; m_armed = 0;
      exp_q.push_back(9'd0);
    end else begin
      rise = db_in & ~m_prev & m_armed;
      fall = ~db_in & m_prev;
      if (m_run == 0 || db_in != m_last) m_run = 1;
      else m_run = m_run + 1;
      m_last  = db_in;
      m_armed = m_armed | ~db_in;
      m_prev  = db_in;
      if (!en) m_mode = 0;
      else begin
        case (m_mode)
          0: if (rise) begin m_mode = 1; p = 1; end
          1: if (fall) begin m_mode = 2; r = 1; end
             else if (m_run == LONG) begin m_mode = 4; l = 1; end
          2: if (rise) begin m_mode = 3; p = 1; end
             else if (m_run == GAP) begin m_mode = 0; s = 1; end
          3: if (fall) begin m_mode = 0; r = 1; d = 1; end
             else if (m_run == LONG) begin m_mode = 4; l = 1; end
          default: if (fall) begin m_mode = 0; r = 1; end
             else if (m_run > LONG && ((m_run - LONG) % REP) == 0) rp = 1;
        endcase
      end
      exp_q.push_back({3'(m_mode), p, r, s, d, l, rp});
    end
  end

  // Scoreboard: one compare per cycle, away from the active edge.
  always @(negedge clk) begin
    logic [8:0] act, exp;
    #1;
    act = {state_o, press_pulse, release_pulse, single_click, double_click, long_press, repeat_pulse};
    if (!rst_n) begin
      exp_q.delete();
      checks++;
      if (act !== 9'd0) begin
        errors++;
        $display("FAIL reset_outputs t=%0t actual=%b required=%b", $time, act, 9'd0);
      end
    end else if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t actual=%b required=%b", $time, act, exp);
      end
      cnt_press  += int'(press_pulse);
      cnt_rel    += int'(release_pulse);
      cnt_single += int'(single_click);
      cnt_double += int'(double_click);
      cnt_long   += int'(long_press);
      cnt_rep    += int'(repeat_pulse);
    end
  end

  // driver tasks
  task automatic hold(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      db_in = lvl;
      @(negedge clk);
    end
  endtask

  task automatic clear_counts();
    #2;
    cnt_press = 0; cnt_rel = 0; cnt_single = 0;
    cnt_double = 0; cnt_long = 0; cnt_rep = 0;
  endtask

  task automatic check_counts(input string name, input int ep, input int er, input int es,
                              input int ed, input int el, input int erp);
    #2;
    checks++;
    if (cnt_press != ep || cnt_rel != er || cnt_single != es ||
        cnt_double != ed || cnt_long != el || cnt_rep != erp) begin
      errors++;
      $display("FAIL %s actual p%0d r%0d s%0d d%0d l%0d rp%0d required p%0d r%0d s%0d d%0d l%0d rp%0d",
               name, cnt_press, cnt_rel, cnt_single, cnt_double, cnt_long, cnt_rep,
               ep, er, es, ed, el, erp);
    end
  endtask

  initial begin
    @(negedge clk);
    // Reset with the button held high: no press after release until low then high.
    db_in = 1'b1;
    hold(1, 3);
    rst_n = 1'b1;
    clear_counts();
    hold(1, 5);
    hold(0, 3);
    check_counts("reset_no_press", 0, 0, 0, 0, 0, 0);

    clear_counts();
    hold(1, 3); hold(0, 7);
    check_counts("single_click", 1, 1, 1, 0, 0, 0);

    clear_counts();
    hold(1, 3); hold(0, 4); hold(1, 2); hold(0, 8);
    check_counts("double_click", 2, 2, 0, 1, 0, 0);

    clear_counts();
    hold(1, 3); hold(0, 5); hold(1, 3); hold(0, 8);
    check_counts("gap_boundary", 2, 2, 2, 0, 0, 0);

    clear_counts();
    hold(1, 15); hold(0, 8);
    check_counts("long_repeat", 1, 1, 0, 0, 1, 2);

    clear_counts();
    hold(1, 4);
    en = 1'b0;
    hold(1, 3);
    en = 1'b1;
    hold(1, 4); hold(0, 8);
    check_counts("enable_gating", 1, 0, 0, 0, 0, 0);

    // randomized level runs, occasional enable drops and resets
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 60) == 0) begin
        rst_n = 1'b0;
        hold(db_in, $urandom_range(2, 4));
        rst_n = 1'b1;
      end
      en = ($urandom_range(0, 12) != 0);
      if ($urandom_range(0, 5) == 0) hold(~db_in, $urandom_range(8, 20));
      else hold(~db_in, $urandom_range(1, 7));
    end
    en = 1'b1;
    hold(0, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
